// File: rtl/instr_encode_loader.sv
// Packs assembled SCRISC-16 instruction fields into 16-bit words and streams them
// sequentially into instruction memory, range-checking immediates on the way.
module instr_encode_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [2:0]        in_rd,
  input  logic [2:0]        in_rs,
  input  logic [2:0]        in_rt,
  input  logic [1:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_CHECK,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [4:0]        op_q;
  logic [2:0]        rd_q, rs_q, rt_q;
  logic [1:0]        funct_q;
  logic [15:0]       imm_q;
  logic              last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic              err_q;
  logic [1:0]        err_code_q;
  logic              in_ready_q, busy_q, done_q, we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [15:0]       wdata_q;

  logic        is_r, is_d, is_uns;
  logic [15:0] word_d;
  logic        range_ok;
  logic        overflow;

  // Format and range are decided from the captured opcode; op[0] selects unsigned range.
  always_comb begin
    is_r   = (op_q == 5'b11111);
    is_d   = (op_q[4:2] == 3'b000);
    is_uns = op_q[0];
    if (is_r) begin
      word_d   = {op_q, rd_q, rs_q, rt_q, funct_q};
      range_ok = 1'b1;
    end else if (is_d) begin
      word_d   = {op_q, 2'b00, imm_q[8:0]};
      range_ok = is_uns ? (imm_q[15:9] == '0)
                        : ((imm_q[15:8] == '0) || (imm_q[15:8] == '1));
    end else begin
      word_d   = {op_q, rd_q, 1'b0, imm_q[6:0]};
      range_ok = is_uns ? (imm_q[15:7] == '0)
                        : ((imm_q[15:6] == '0) || (imm_q[15:6] == '1));
    end
    overflow = !last_q && (addr_q == '1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_ACCEPT;
      S_ACCEPT: if (in_valid) state_d = S_CHECK;
      S_CHECK:  state_d = range_ok ? S_WRITE : S_IDLE;
      S_WRITE:  state_d = last_q ? S_DONE : (overflow ? S_IDLE : S_ACCEPT);
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Status strobes are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      funct_q    <= '0;
      imm_q      <= '0;
      last_q     <= 1'b0;
      addr_q     <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == S_ACCEPT);
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
      we_q       <= (state_d == S_WRITE);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q     <= base_addr;
            count_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
          end
        end
        S_ACCEPT: begin
          if (in_valid) begin
            op_q    <= in_op;
            rd_q    <= in_rd;
            rs_q    <= in_rs;
            rt_q    <= in_rt;
            funct_q <= in_funct;
            imm_q   <= in_imm;
            last_q  <= in_last;
          end
        end
        S_CHECK: begin
          if (range_ok) begin
            waddr_q <= addr_q;
            wdata_q <= word_d;
          end else begin
            err_q      <= 1'b1;
            err_code_q <= 2'b01;
          end
        end
        S_WRITE: begin
          count_q <= count_q + COUNT_ONE;
          if (!last_q) begin
            if (overflow) begin
              err_q      <= 1'b1;
              err_code_q <= 2'b10;
            end else begin
              addr_q <= addr_q + ADDR_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: expected imem writes go into a scoreboard
// queue as words are issued; a negedge monitor pops and compares each write.
module tb_instr_encode_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_op = '0;
  logic [2:0]  in_rd = '0, in_rs = '0, in_rt = '0;
  logic [1:0]  in_funct = '0;
  logic [15:0] in_imm = '0;
  logic        in_last = 1'b0;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [8:0]  word_count;

  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int cyc = 0;
  int last_we_cyc = -1;
  logic [23:0] exp_q[$];

  instr_encode_loader #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs(in_rs), .in_rt(in_rt), .in_funct(in_funct), .in_imm(in_imm),
    .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .word_count(word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (done) done_seen++;
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", imem_addr, imem_wdata);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        check("write", {40'd0, imem_addr, imem_wdata}, {40'd0, e});
      end
      if (last_we_cyc >= 0) check("we_spacing", 64'(cyc - last_we_cyc >= 3), 64'd1);
      last_we_cyc = cyc;
    end
  end

  task automatic pulse_start(input logic [7:0] b);
    start = 1'b1;
    base_addr = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs,
                      input logic [2:0] rt, input logic [1:0] fn, input logic [15:0] imm,
                      input logic last, input int gap, input logic exp_wr,
                      input logic [7:0] ea, input logic [15:0] ew, output logic acc);
    repeat (gap) @(negedge clk);
    in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_funct = fn;
    in_imm = imm; in_last = last; in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 12 && !acc; i++) begin
      @(posedge clk);
      if (in_ready) acc = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (acc && exp_wr) exp_q.push_back({ea, ew});
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic check_status(input string name, input logic e, input logic [1:0] c,
                              input logic [8:0] cnt, input int d0, input int dexp);
    check({name, "_err"}, 64'(err), 64'(e));
    check({name, "_code"}, 64'(err_code), 64'(c));
    check({name, "_count"}, 64'(word_count), 64'(cnt));
    check({name, "_done"}, 64'(done_seen - d0), 64'(dexp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int d0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_outs", {24'd0, imem_we, in_ready, busy, done, err, err_code, imem_addr, imem_wdata, word_count}, 64'd0);

    // 1: single R-type word
    d0 = done_seen;
    pulse_start(8'h10);
    check("accept_ready", 64'({in_ready, busy}), 64'b11);
    send(5'b11111, 3'd1, 3'd2, 3'd3, 2'd2, 16'h0000, 1'b1, 0, 1'b1, 8'h10, 16'hF94E, acc);
    wait_idle("t1");
    check_status("t1", 1'b0, 2'b00, 9'd1, d0, 1);
    check("t1_addr_hold", 64'({imem_we, imem_addr}), 64'h010);

    // 2: I-type signed pass, unsigned failures
    d0 = done_seen;
    pulse_start(8'h20);
    send(5'b01110, 3'd5, 3'd0, 3'd0, 2'd0, 16'hFFFF, 1'b1, 0, 1'b1, 8'h20, 16'h757F, acc);
    wait_idle("t2a");
    check_status("t2a", 1'b0, 2'b00, 9'd1, d0, 1);

    d0 = done_seen;
    pulse_start(8'h30);
    send(5'b00101, 3'd0, 3'd0, 3'd0, 2'd0, 16'd128, 1'b1, 0, 1'b0, 8'h00, 16'h0000, acc);
    wait_idle("t2b");
    check_status("t2b", 1'b1, 2'b01, 9'd0, d0, 0);
    check("t2b_addr_hold", 64'(imem_addr), 64'h20);

    d0 = done_seen;
    pulse_start(8'h30);
    check("t2c_err_cleared", 64'({err, err_code}), 64'd0);
    send(5'b01111, 3'd5, 3'd0, 3'd0, 2'd0, 16'hFFFF, 1'b1, 0, 1'b0, 8'h00, 16'h0000, acc);
    wait_idle("t2c");
    check_status("t2c", 1'b1, 2'b01, 9'd0, d0, 0);

    // 3: D-type boundaries, last word fails so no done
    d0 = done_seen;
    pulse_start(8'h40);
    send(5'b00001, 3'd0, 3'd0, 3'd0, 2'd0, 16'd511, 1'b0, 0, 1'b1, 8'h40, 16'h09FF, acc);
    send(5'b00010, 3'd0, 3'd0, 3'd0, 2'd0, 16'hFF00, 1'b0, 1, 1'b1, 8'h41, 16'h1100, acc);
    send(5'b00000, 3'd0, 3'd0, 3'd0, 2'd0, 16'hFEFF, 1'b1, 0, 1'b0, 8'h00, 16'h0000, acc);
    wait_idle("t3");
    check_status("t3", 1'b1, 2'b01, 9'd2, d0, 0);

    // 4: address overflow, then all-ones with last completes
    d0 = done_seen;
    pulse_start(8'hFE);
    send(5'b01000, 3'd3, 3'd0, 3'd0, 2'd0, 16'd5, 1'b0, 0, 1'b1, 8'hFE, 16'h4305, acc);
    send(5'b01000, 3'd3, 3'd0, 3'd0, 2'd0, 16'hFFC0, 1'b0, 0, 1'b1, 8'hFF, 16'h4340, acc);
    send(5'b01000, 3'd3, 3'd0, 3'd0, 2'd0, 16'd1, 1'b0, 0, 1'b0, 8'h00, 16'h0000, acc);
    check("t4_third_rejected", 64'(acc), 64'd0);
    wait_idle("t4");
    check_status("t4", 1'b1, 2'b10, 9'd2, d0, 0);

    d0 = done_seen;
    pulse_start(8'hFF);
    send(5'b01010, 3'd1, 3'd0, 3'd0, 2'd0, 16'd0, 1'b1, 0, 1'b1, 8'hFF, 16'h5100, acc);
    wait_idle("t4b");
    check_status("t4b", 1'b0, 2'b00, 9'd1, d0, 1);

    // 5: four-word stream with valid gaps
    d0 = done_seen;
    pulse_start(8'h50);
    send(5'b11111, 3'd7, 3'd7, 3'd7, 2'd3, 16'd0, 1'b0, 0, 1'b1, 8'h50, 16'hFFFF, acc);
    send(5'b00111, 3'd0, 3'd0, 3'd0, 2'd0, 16'd127, 1'b0, 2, 1'b1, 8'h51, 16'h387F, acc);
    send(5'b00011, 3'd0, 3'd0, 3'd0, 2'd0, 16'd0, 1'b0, 1, 1'b1, 8'h52, 16'h1800, acc);
    send(5'b10000, 3'd2, 3'd0, 3'd0, 2'd0, 16'd63, 1'b1, 3, 1'b1, 8'h53, 16'h823F, acc);
    wait_idle("t5");
    check_status("t5", 1'b0, 2'b00, 9'd4, d0, 1);

    // 6a: reset while the word sits in CHECK
    d0 = done_seen;
    pulse_start(8'h60);
    send(5'b01000, 3'd1, 3'd0, 3'd0, 2'd0, 16'd1, 1'b1, 0, 1'b0, 8'h00, 16'h0000, acc);
    reset = 1'b1;
    @(negedge clk);
    check("t6a_reset_outs", {24'd0, imem_we, in_ready, busy, done, err, err_code, imem_addr, imem_wdata, word_count}, 64'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("t6a_no_done", 64'(done_seen - d0), 64'd0);

    // 6b: start during ACCEPT is ignored
    d0 = done_seen;
    pulse_start(8'h70);
    @(negedge clk);
    pulse_start(8'h90);
    check("t6b_still_accept", 64'({in_ready, busy}), 64'b11);
    send(5'b11111, 3'd0, 3'd0, 3'd0, 2'd1, 16'd0, 1'b1, 0, 1'b1, 8'h70, 16'hF801, acc);
    wait_idle("t6b");
    check_status("t6b", 1'b0, 2'b00, 9'd1, d0, 1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
